// File: rtl/service_scheduler_if.sv
// Signal bundle between the service scheduler and its switches, button, services and display.
// The scheduler sits on the slave modport; whatever drives switches and BCD values uses master.
interface service_scheduler_if;
    logic [2:0]  spdt;
    logic        push_m_raw;
    logic [15:0] svc1_bcd;
    logic [15:0] svc2_bcd;
    logic [15:0] svc3_bcd;
    logic [2:0]  svc_en;
    logic [1:0]  owner;
    logic [2:0]  push_pulse;
    logic        tick;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        blank;

    modport master (
        output spdt, push_m_raw, svc1_bcd, svc2_bcd, svc3_bcd,
        input  svc_en, owner, push_pulse, tick, an, digit, blank
    );

    modport slave (
        input  spdt, push_m_raw, svc1_bcd, svc2_bcd, svc3_bcd,
        output svc_en, owner, push_pulse, tick, an, digit, blank
    );
endinterface

// File: rtl/service_scheduler.sv
// Arbitrates a shared push button, count tick and 4-digit display among three services
// selected by switches, with a blanking window on every ownership change.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no service requested; display dark, no grants
// S_BLANK  | owner latched, waiting BLANK_CYCLES before granting
// S_ACTIVE | owner granted; tick, push routing and display enabled
module service_scheduler #(
    parameter int TICK_DIV     = 1000,
    parameter int SCAN_DIV     = 100,
    parameter int BLANK_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    service_scheduler_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BLANK  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    spdt_s1_q, spdt_s2_q;
    logic          push_s1_q, push_s2_q, push_prev_q;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    req;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick_q, tick_d;
    logic [2:0]    pulse_q, pulse_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    scan_idx_q, scan_idx_d;
    logic          push_edge;
    logic [15:0]   sel_bcd;

    function automatic logic [2:0] onehot(input logic [1:0] num);
        logic [2:0] oh;
        oh = 3'b000;
        case (num)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spdt_s1_q   <= 3'b000;
            spdt_s2_q   <= 3'b000;
            push_s1_q   <= 1'b0;
            push_s2_q   <= 1'b0;
            push_prev_q <= 1'b0;
        end else begin
            spdt_s1_q   <= bus.spdt;
            spdt_s2_q   <= spdt_s1_q;
            push_s1_q   <= bus.push_m_raw;
            push_s2_q   <= push_s1_q;
            push_prev_q <= push_s2_q;
        end
    end

    // Highest-numbered requesting service wins.
    always_comb begin
        req = 2'd0;
        if (spdt_s2_q[2]) begin
            req = 2'd3;
        end else if (spdt_s2_q[1]) begin
            req = 2'd2;
        end else if (spdt_s2_q[0]) begin
            req = 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= 2'd0;
            blank_cnt_q <= '0;
            tick_cnt_q  <= '0;
            tick_q      <= 1'b0;
            pulse_q     <= 3'b000;
            scan_cnt_q  <= '0;
            scan_idx_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            blank_cnt_q <= blank_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            tick_q      <= tick_d;
            pulse_q     <= pulse_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_idx_q  <= scan_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        blank_cnt_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req != 2'd0) begin
                    state_d = S_BLANK;
                    owner_d = req;
                end
            end
            S_BLANK: begin
                if (req == 2'd0) begin
                    state_d = S_IDLE;
                    owner_d = 2'd0;
                end else if (req != owner_q) begin
                    owner_d = req;
                end else if (blank_cnt_q == BLANK_LAST) begin
                    state_d = S_ACTIVE;
                end else begin
                    blank_cnt_d = blank_cnt_q + BW'(1);
                end
            end
            S_ACTIVE: begin
                if (req == 2'd0) begin
                    state_d = S_IDLE;
                    owner_d = 2'd0;
                end else if (req != owner_q) begin
                    state_d = S_BLANK;
                    owner_d = req;
                end
            end
            default: begin
                state_d = S_IDLE;
                owner_d = 2'd0;
            end
        endcase
    end

    // Tick and push only act while ACTIVE persists across the edge, so events
    // coinciding with a hand-over are dropped rather than reaching the old owner.
    assign push_edge = push_s2_q & ~push_prev_q;

    always_comb begin
        tick_cnt_d = '0;
        tick_d     = 1'b0;
        pulse_d    = 3'b000;
        if (state_q == S_ACTIVE && state_d == S_ACTIVE) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
            if (push_edge) begin
                pulse_d = onehot(owner_q);
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
    end

    always_comb begin
        case (owner_q)
            2'd1:    sel_bcd = bus.svc1_bcd;
            2'd2:    sel_bcd = bus.svc2_bcd;
            2'd3:    sel_bcd = bus.svc3_bcd;
            default: sel_bcd = 16'h0000;
        endcase
    end

    always_comb begin
        bus.svc_en = 3'b000;
        bus.an     = 4'b1111;
        bus.digit  = 4'h0;
        bus.blank  = 1'b1;
        if (state_q == S_ACTIVE) begin
            bus.svc_en = onehot(owner_q);
            bus.an     = ~(4'b0001 << scan_idx_q);
            bus.digit  = sel_bcd[{scan_idx_q, 2'b00} +: 4];
            bus.blank  = 1'b0;
        end
    end

    assign bus.owner      = owner_q;
    assign bus.tick       = tick_q;
    assign bus.push_pulse = pulse_q;
endmodule

// File: tb/tb_service_scheduler.sv
// Bench for service_scheduler: a behavioural ownership/timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_service_scheduler;
    localparam int TICK_DIV     = 10;
    localparam int SCAN_DIV     = 5;
    localparam int BLANK_CYCLES = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    service_scheduler_if bus();

    service_scheduler #(
        .TICK_DIV    (TICK_DIV),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: owner plus remaining blank cycles, age since grant, edges since reset.
    logic [2:0] m_sp1, m_sp2;
    logic       m_pb1, m_pb2, m_pb3;
    int         m_owner, m_blank_left, m_age, m_edges;
    logic [2:0] m_pulse;
    logic       m_tick;

    function automatic int req_of(input logic [2:0] s);
        for (int b = 2; b >= 0; b--) if (s[b]) return b + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_sp1 = 3'b000; m_sp2 = 3'b000;
        m_pb1 = 1'b0; m_pb2 = 1'b0; m_pb3 = 1'b0;
        m_owner = 0; m_blank_left = 0; m_age = 0; m_edges = 0;
        m_pulse = 3'b000; m_tick = 1'b0;
    endtask

    task automatic model_step();
        int rq;
        bit was_act, is_act, pedge;
        rq      = req_of(m_sp2);
        was_act = (m_owner != 0 && m_blank_left == 0);
        pedge   = m_pb2 && !m_pb3;
        if (rq == 0) begin
            m_owner = 0; m_blank_left = 0;
        end else if (rq != m_owner) begin
            m_owner = rq; m_blank_left = BLANK_CYCLES;
        end else if (m_blank_left > 0) begin
            m_blank_left--;
        end
        is_act  = (m_owner != 0 && m_blank_left == 0);
        m_age   = (was_act && is_act) ? m_age + 1 : 0;
        m_tick  = is_act && m_age > 0 && (m_age % TICK_DIV) == 0;
        m_pulse = (was_act && is_act && pedge) ? 3'(1 << (m_owner - 1)) : 3'b000;
        m_pb3 = m_pb2; m_pb2 = m_pb1; m_pb1 = bus.push_m_raw;
        m_sp2 = m_sp1; m_sp1 = bus.spdt;
        m_edges++;
    endtask

    task automatic compare_all();
        bit          act;
        int          idx;
        logic [15:0] b;
        act = (m_owner != 0 && m_blank_left == 0);
        idx = (m_edges / SCAN_DIV) % 4;
        b   = (m_owner == 1) ? bus.svc1_bcd : (m_owner == 2) ? bus.svc2_bcd :
              (m_owner == 3) ? bus.svc3_bcd : 16'h0000;
        chk("owner",      bus.owner,      m_owner);
        chk("svc_en",     bus.svc_en,     act ? (1 << (m_owner - 1)) : 0);
        chk("blank",      bus.blank,      act ? 0 : 1);
        chk("an",         bus.an,         act ? (~(1 << idx)) & 4'hF : 4'hF);
        chk("digit",      bus.digit,      act ? (b >> (4 * idx)) & 16'hF : 0);
        chk("tick",       bus.tick,       m_tick);
        chk("push_pulse", bus.push_pulse, m_pulse);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (reset) model_reset(); else model_step();
            @(negedge clk);
            if (reset) model_reset();
            compare_all();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] an_tbl  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] dig_tbl [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    initial begin
        bit         found;
        logic [3:0] prev_an;
        int         pcnt;
        logic [2:0] pval;

        bus.spdt = 3'b000; bus.push_m_raw = 1'b0;
        bus.svc1_bcd = 16'h5678; bus.svc2_bcd = 16'h9abc; bus.svc3_bcd = 16'h1234;
        repeat (3) step();
        chk("rst_owner", bus.owner, 0);
        chk("rst_an", bus.an, 4'hF);
        chk("rst_blank", bus.blank, 1);
        reset = 1'b0;

        // Single request for service 3: sync, blank window, then first tick.
        bus.spdt = 3'b100;
        step(); step();
        chk("own_before_sync", bus.owner, 0);
        step();
        chk("own_after_sync", bus.owner, 3);
        chk("svc_en_in_blank", bus.svc_en, 0);
        repeat (BLANK_CYCLES - 1) step();
        chk("svc_en_blank_end", bus.svc_en, 0);
        step();
        chk("svc_en_grant", bus.svc_en, 3'b100);
        chk("blank_grant", bus.blank, 0);
        repeat (TICK_DIV - 1) step();
        chk("tick_early", bus.tick, 0);
        step();
        chk("tick_first", bus.tick, 1);
        step();
        chk("tick_single", bus.tick, 0);

        // Display scan of svc3_bcd = 1234.
        found = 1'b0;
        prev_an = bus.an;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (bus.an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
            prev_an = bus.an;
        end
        chk("scan_align", found, 1);
        for (int i = 0; i < 4; i++) begin
            chk("scan_an_first", bus.an, an_tbl[i]);
            chk("scan_digit_first", bus.digit, dig_tbl[i]);
            repeat (SCAN_DIV - 1) step();
            chk("scan_an_last", bus.an, an_tbl[i]);
            chk("scan_digit_last", bus.digit, dig_tbl[i]);
            step();
        end

        // Priority and hand-over from 3 to 2.
        bus.spdt = 3'b111;
        repeat (5) step();
        chk("prio_owner", bus.owner, 3);
        bus.spdt = 3'b011;
        repeat (3) step();
        chk("handover_owner", bus.owner, 2);
        chk("handover_blank", bus.blank, 1);
        repeat (BLANK_CYCLES) step();
        chk("handover_svc_en", bus.svc_en, 3'b010);
        repeat (TICK_DIV - 1) step();
        chk("handover_tick_early", bus.tick, 0);
        step();
        chk("handover_tick", bus.tick, 1);

        // Held button gives one pulse; press during blanking gives none.
        bus.push_m_raw = 1'b1;
        pcnt = 0; pval = 3'b000;
        repeat (50) begin
            step();
            if (bus.push_pulse != 3'b000) begin pcnt++; pval = bus.push_pulse; end
        end
        chk("push_held_count", pcnt, 1);
        chk("push_held_value", pval, 3'b010);
        bus.push_m_raw = 1'b0;
        repeat (5) step();
        bus.spdt = 3'b001;
        repeat (3) step();
        chk("push_blank_state", bus.blank, 1);
        bus.push_m_raw = 1'b1;
        pcnt = 0;
        repeat (BLANK_CYCLES + 6) begin
            step();
            if (bus.push_pulse != 3'b000) pcnt++;
        end
        chk("push_in_blank", pcnt, 0);
        bus.push_m_raw = 1'b0;

        // Glitch to service 2 inside the blank window restarts blanking.
        bus.spdt = 3'b000;
        repeat (6) step();
        chk("idle_owner", bus.owner, 0);
        bus.spdt = 3'b001;
        repeat (3) step();
        chk("glitch_owner1", bus.owner, 1);
        bus.spdt = 3'b010;
        step();
        bus.spdt = 3'b001;
        step(); step();
        chk("glitch_owner2", bus.owner, 2);
        step();
        chk("glitch_back", bus.owner, 1);
        for (int k = 0; k < BLANK_CYCLES - 1; k++) begin
            step();
            chk("glitch_no_en", bus.svc_en, 0);
            chk("glitch_no_tick", bus.tick, 0);
        end
        step();
        chk("glitch_grant", bus.svc_en, 3'b001);

        // Asynchronous reset while ACTIVE, then the full window again.
        repeat (5) step();
        #1;
        reset = 1'b1;
        #1;
        chk("arst_svc_en", bus.svc_en, 0);
        chk("arst_owner", bus.owner, 0);
        chk("arst_pulse", bus.push_pulse, 0);
        chk("arst_tick", bus.tick, 0);
        chk("arst_an", bus.an, 4'hF);
        chk("arst_digit", bus.digit, 0);
        chk("arst_blank", bus.blank, 1);
        step();
        reset = 1'b0;
        step(); step();
        chk("rel_owner_sync", bus.owner, 0);
        step();
        chk("rel_owner", bus.owner, 1);
        repeat (BLANK_CYCLES - 1) step();
        chk("rel_svc_en_blank", bus.svc_en, 0);
        step();
        chk("rel_svc_en", bus.svc_en, 3'b001);

        repeat (5) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule

// File: doc/service_scheduler.md
SERVICE_SCHEDULER -- requirements
Module: service_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 1000, clk cycles per count tick issued to the active service.
REQ-002 Parameter SCAN_DIV, default 100, clk cycles each display digit stays selected.
REQ-003 Parameter BLANK_CYCLES, default 4, length of the blanking window on each ownership change.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 spdt  in  3  raw service-select switches; bit0 = service 1, bit1 = service 2, bit2 = service 3.
REQ-007 push_m_raw  in  1  raw shared push button.
REQ-008 svc1_bcd, svc2_bcd, svc3_bcd  in  16 each  4-digit BCD display value from each service; [15:12] is the leftmost digit.
REQ-009 svc_en  out  3  one-hot grant to the owning service; 000 when there is no owner or during blanking.
REQ-010 owner  out  2  current owner: 0 none, 1 to 3 service number.
REQ-011 push_pulse  out  3  one-cycle push event, routed only to the owner's bit.
REQ-012 tick  out  1  one-cycle count-enable pulse, valid only while state is ACTIVE.
REQ-013 an  out  4  active-low digit enable; an[3] selects the leftmost digit.
REQ-014 digit  out  4  BCD nibble for the selected digit.
REQ-015 blank  out  1  high when the display is dark (IDLE or BLANK state).

Function
REQ-016 spdt and push_m_raw each pass through a 2-flop synchronizer; all logic uses only the synchronized values.
REQ-017 The requested owner is the highest-numbered synchronized spdt bit that is set (priority 3 > 2 > 1); it is 0 if no bit is set.
REQ-018 The FSM has three states: IDLE, BLANK and ACTIVE.
REQ-019 FSM transition, IDLE: the FSM goes to BLANK when the requested owner is nonzero.
REQ-020 FSM transition, BLANK: the FSM goes to ACTIVE after BLANK_CYCLES cycles.
REQ-021 FSM transition, ACTIVE: the FSM goes to BLANK when the requested owner changes to a different nonzero value, and goes to IDLE when the requested owner becomes 0.
REQ-022 owner updates to the requested owner on entry to BLANK and clears to 0 on entry to IDLE.
REQ-023 svc_en equals onehot(owner) only in ACTIVE.
REQ-024 If the requested owner changes while in BLANK, owner updates and the blank counter restarts from 0; if it becomes 0, the FSM goes to IDLE.
REQ-025 push_pulse[owner-1] is high for exactly one cycle, in the cycle after the synchronized button makes a 0 to 1 transition; total latency is 3 rising edges from the raw rise.
REQ-026 A push edge occurring in IDLE or BLANK, or in the same cycle as an ACTIVE to BLANK or ACTIVE to IDLE transition, is dropped and is not queued.
REQ-027 A held button produces exactly one pulse; a new pulse requires a release followed by a press.
REQ-028 The tick counter runs from 0 to TICK_DIV-1, is cleared on every entry to ACTIVE, and pulses tick when it wraps; the first tick comes TICK_DIV cycles after ACTIVE entry.
REQ-029 The tick counter is held at 0 outside ACTIVE, and tick stays 0 there.
REQ-030 The scan index (0 to 3) advances every SCAN_DIV cycles and wraps from 3 to 0; it runs freely in all states.
REQ-031 Scan index i drives an = ~(4'b0001 << i) and drives digit from the owner's bcd nibble [4i+3:4i].
REQ-032 In IDLE and BLANK, an = 1111, digit = 0000 and blank = 1; in ACTIVE, blank = 0.
REQ-033 Counter widths are sized by $clog2 of the corresponding parameter; no counter may overflow past its terminal value.

Reset
REQ-034 While reset is high, the FSM is IDLE, the synchronizers and all counters are 0, owner=0, svc_en=000, push_pulse=000, tick=0, an=1111, digit=0000 and blank=1.
REQ-035 Reset asserted mid-operation takes effect immediately, without waiting for a clock edge.
REQ-036 After reset is released, the first ownership requires full synchronization plus a full BLANK_CYCLES window.

Verification
REQ-037 Set spdt=100 at t0 -> owner=3 at t0+3 edges; svc_en=100 and blank=0 at t0+3+BLANK_CYCLES; first tick TICK_DIV cycles after that.
REQ-038 spdt=111 -> owner=3; then clear bit2 while in ACTIVE -> BLANK with owner=2, then ACTIVE with svc_en=010 and tick restarted.
REQ-039 Owner 3 ACTIVE with svc3_bcd=16'h1234 -> an and digit step through 1110/4, 1101/3, 1011/2, 0111/1, each held SCAN_DIV cycles.
REQ-040 Owner 2 ACTIVE, hold the button 50 cycles -> exactly one push_pulse=010; a press during BLANK -> no pulse.
REQ-041 Toggle spdt from 001 to 010 and back to 001 inside the blank window -> blank counter restarts, owner=1, no tick and no svc_en during blanking.
REQ-042 Assert reset while ACTIVE -> all outputs take their REQ-034 values with no clock edge; after release with spdt unchanged, the full blank window is repeated.
